// File: rtl/counter_pkg.sv
// counter_pkg: shared rate-select codes and prescaler sizing helper
package counter_pkg;

    localparam logic [1:0] RATE_X1 = 2'd0;
    localparam logic [1:0] RATE_X2 = 2'd1;
    localparam logic [1:0] RATE_X4 = 2'd2;
    localparam logic [1:0] RATE_X8 = 2'd3;

    function automatic int presc_width(input int base);
        return $clog2(base);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divider that pulses term once every (BASE >> rate_sel) enabled cycles
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int BASE = 12_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] rate_sel,
    output logic       term
);

    localparam int PW = presc_width(BASE);

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   last;

    // Terminal uses >= so a rate change below the current count fires at once
    always_comb begin
        last    = (32'(BASE) >> rate_sel) - 32'd1;
        term    = en && !clr && (32'(presc_q) >= last);
        presc_d = (clr || term) ? '0 : en ? presc_q + PW'(1) : presc_q;
    end

    // Prescaler register; holds while disabled so partial periods survive a pause
    always_ff @(posedge clk) begin
        if (rst) presc_q <= '0;
        else     presc_q <= presc_d;
    end

endmodule

// File: rtl/auto_tick_counter.sv
// auto_tick_counter: run/pause, up/down, multi-rate LED counter with wrap or saturate limits
module auto_tick_counter
    import counter_pkg::*;
#(
    parameter int CLK_HZ        = 12_000_000,
    parameter int TICK_HZ       = 1,
    parameter int WIDTH         = 4,
    parameter int SATURATE      = 0,
    parameter bit START_RUNNING = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run_toggle,
    input  logic             dir,
    input  logic [1:0]       rate_sel,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             limit_evt,
    output logic             running
);

    localparam int BASE = CLK_HZ / TICK_HZ;

    if (BASE % 8 != 0) begin : g_base_chk
        $error("auto_tick_counter: CLK_HZ/TICK_HZ must be a multiple of 8");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_width_chk
        $error("auto_tick_counter: WIDTH must be 1..32");
    end

    logic             term;
    logic             rt_q;
    logic             running_q, running_d;
    logic [WIDTH-1:0] count_q, count_d, stepped;
    logic             tick_q;
    logic             limit_q, limit_d;
    logic             at_limit;

    tick_prescaler #(.BASE(BASE)) u_presc (
        .clk      (clk),
        .rst      (rst),
        .en       (running_q),
        .clr      (clear),
        .rate_sel (rate_sel),
        .term     (term)
    );

    // Next count, limit event and run flag; clear wins over any tick
    always_comb begin
        at_limit  = dir ? (count_q == '0) : (count_q == '1);
        stepped   = dir ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
        count_d   = clear ? '0 : !term ? count_q : (at_limit && SATURATE != 0) ? count_q : stepped;
        limit_d   = term && at_limit;
        running_d = running_q ^ (run_toggle && !rt_q);
    end

    // Output and state registers; edge history resets high to ignore buttons held through reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rt_q      <= 1'b1;
            running_q <= START_RUNNING;
            count_q   <= '0;
            tick_q    <= 1'b0;
            limit_q   <= 1'b0;
        end else begin
            rt_q      <= run_toggle;
            running_q <= running_d;
            count_q   <= count_d;
            tick_q    <= term;
            limit_q   <= limit_d;
        end
    end

    assign count     = count_q;
    assign tick      = tick_q;
    assign limit_evt = limit_q;
    assign running   = running_q;

endmodule
